// File: rtl/mtr_seq_pkg.sv
// Shared types and hall-sensor helpers for the motor sequencing controller.
package mtr_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StCoast,
    StBrake,
    StFault
  } state_e;

  typedef enum logic [1:0] {
    FltNone    = 2'b00,
    FltInvHall = 2'b01,
    FltSkip    = 2'b10,
    FltStall   = 2'b11
  } fault_e;

  // Step index returned for the two impossible hall codes.
  localparam logic [2:0] HallInvIdx = 3'd7;

  // Forward commutation order 101,100,110,010,011,001 maps to steps 0..5.
  function automatic logic [2:0] hall_idx(input logic [2:0] hall);
    logic [2:0] idx;
    case (hall)
      3'b101:  idx = 3'd0;
      3'b100:  idx = 3'd1;
      3'b110:  idx = 3'd2;
      3'b010:  idx = 3'd3;
      3'b011:  idx = 3'd4;
      3'b001:  idx = 3'd5;
      default: idx = HallInvIdx;
    endcase
    return idx;
  endfunction

  // True when two valid step indices are one step apart on the 6-step ring.
  function automatic logic hall_adjacent(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] a_p1;
    logic [2:0] b_p1;
    a_p1 = (a >= 3'd5) ? 3'd0 : a + 3'd1;
    b_p1 = (b >= 3'd5) ? 3'd0 : b + 3'd1;
    return (a_p1 == b) || (b_p1 == a);
  endfunction

endpackage

// File: rtl/mtr_seq_ctrl_mag_ramp.sv
// Drive magnitude register: slew-limited rise on PWM_synch, immediate fall, cleared when not running.
module mtr_seq_ctrl_mag_ramp #(
  parameter logic [11:0] RampStep = 12'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_run,
  input  logic        i_pwm_synch,
  input  logic [11:0] i_mag_req,
  output logic [11:0] o_mag
);

  logic [11:0] r_mag;
  logic [11:0] w_mag_d;
  logic [11:0] w_gap;

  // Next magnitude: zero outside RUN, follow the request down at once, climb by at most RampStep.
  always_comb begin
    w_gap   = i_mag_req - r_mag;
    w_mag_d = r_mag;
    if (!i_run) begin
      w_mag_d = '0;
    end else if (i_mag_req < r_mag) begin
      w_mag_d = i_mag_req;
    end else if (i_pwm_synch && (w_gap != '0)) begin
      // Never overshoots the request, so the sum cannot pass 12'hFFF.
      w_mag_d = (w_gap > RampStep) ? r_mag + RampStep : i_mag_req;
    end
  end

  // Magnitude register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag <= '0;
    end else begin
      r_mag <= w_mag_d;
    end
  end

  assign o_mag = r_mag;

endmodule

// File: rtl/mtr_seq_ctrl.sv
// Motor sequencing controller: drive gating/ramp, coast-before-brake, hall supervision, speed period.
module mtr_seq_ctrl
  import mtr_seq_pkg::*;
#(
  parameter logic [11:0] RampStep = 12'd8,
  parameter logic [15:0] CoastCyc = 16'd1024,
  parameter logic [2:0]  InvLim   = 3'd4,
  parameter logic [23:0] StallCyc = 24'd5_000_000,
  parameter logic [11:0] StallMag = 12'h200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [11:0] i_drv_mag_req,
  input  logic        i_brake_req_n,
  input  logic [2:0]  i_hall_syn,
  input  logic        i_pwm_synch,
  input  logic        i_clr_fault,
  output logic [11:0] o_drv_mag,
  output logic        o_brake_n,
  output logic        o_fault,
  output logic [1:0]  o_fault_code,
  output logic [19:0] o_commut_period
);

  state_e      r_state;
  logic        r_brake_n;
  logic        r_fault;
  fault_e      r_fault_code;
  logic [15:0] r_coast_cnt;
  logic [2:0]  r_inv_cnt;
  logic [2:0]  r_prev_idx;
  logic        r_prev_vld;
  logic [23:0] r_stall_cnt;
  logic [19:0] r_per_cnt;
  logic [19:0] r_period;

  logic [11:0] w_drv_mag;
  logic [2:0]  w_idx;
  logic [2:0]  w_inv_nxt;
  logic [23:0] w_stall_nxt;
  logic        w_hall_chk;
  logic        w_hall_inv;
  logic        w_hall_move;
  logic        w_adj;
  logic        w_legal;
  logic        w_inv_trip;
  logic        w_skip_trip;
  logic        w_stall_arm;
  logic        w_stall_trip;
  logic        w_fault_hit;
  fault_e      w_fault_code;
  logic        w_run_hold;

  // Hall supervision and fault detection for this clk.
  always_comb begin
    w_idx        = hall_idx(i_hall_syn);
    w_hall_chk   = i_pwm_synch && (r_state != StFault);
    w_hall_inv   = w_hall_chk && (w_idx == HallInvIdx);
    w_inv_nxt    = r_inv_cnt + 3'd1;
    w_hall_move  = w_hall_chk && !w_hall_inv && r_prev_vld && (w_idx != r_prev_idx);
    w_adj        = hall_adjacent(w_idx, r_prev_idx);
    w_legal      = w_hall_move && w_adj;
    w_inv_trip   = w_hall_inv && (w_inv_nxt == InvLim);
    w_skip_trip  = w_hall_move && !w_adj;
    w_stall_arm  = (r_state == StRun) && (w_drv_mag >= StallMag);
    w_stall_nxt  = r_stall_cnt + 24'd1;
    w_stall_trip = w_stall_arm && !w_legal && (w_stall_nxt == StallCyc);
    w_fault_hit  = w_inv_trip || w_skip_trip || w_stall_trip;
    w_fault_code = FltNone;
    if (w_inv_trip) begin
      w_fault_code = FltInvHall;
    end else if (w_skip_trip) begin
      w_fault_code = FltSkip;
    end else if (w_stall_trip) begin
      w_fault_code = FltStall;
    end
    // Magnitude may only be held or ramped while RUN persists into the next clk.
    w_run_hold = (r_state == StRun) && !w_fault_hit && i_brake_req_n && i_en;
  end

  // Sequencing FSM with registered brake and fault outputs tracking the new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_brake_n    <= 1'b1;
      r_fault      <= 1'b0;
      r_fault_code <= FltNone;
      r_coast_cnt  <= '0;
    end else if (w_fault_hit) begin
      r_state      <= StFault;
      r_brake_n    <= 1'b1;
      r_fault      <= 1'b1;
      r_fault_code <= w_fault_code;
    end else begin
      case (r_state)
        StIdle: begin
          if (!i_brake_req_n) begin
            r_state     <= StCoast;
            r_coast_cnt <= 16'd1;
          end else if (i_en) begin
            r_state <= StRun;
          end
        end
        StRun: begin
          if (!i_brake_req_n) begin
            r_state     <= StCoast;
            r_coast_cnt <= 16'd1;
          end else if (!i_en) begin
            r_state <= StIdle;
          end
        end
        StCoast: begin
          if (i_brake_req_n) begin
            r_state <= StIdle;
          end else if (r_coast_cnt == CoastCyc) begin
            r_state   <= StBrake;
            r_brake_n <= 1'b0;
          end else begin
            r_coast_cnt <= r_coast_cnt + 16'd1;
          end
        end
        StBrake: begin
          if (i_brake_req_n) begin
            r_state   <= StIdle;
            r_brake_n <= 1'b1;
          end
        end
        StFault: begin
          if (i_clr_fault) begin
            r_state      <= StIdle;
            r_fault      <= 1'b0;
            r_fault_code <= FltNone;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_brake_n <= 1'b1;
        end
      endcase
    end
  end

  // Invalid-code run length and last valid step; forgotten while faulted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inv_cnt  <= '0;
      r_prev_idx <= '0;
      r_prev_vld <= 1'b0;
    end else if (r_state == StFault) begin
      r_inv_cnt  <= '0;
      r_prev_vld <= 1'b0;
    end else if (i_pwm_synch) begin
      if (w_idx == HallInvIdx) begin
        r_inv_cnt <= w_inv_nxt;
      end else begin
        r_inv_cnt  <= '0;
        r_prev_idx <= w_idx;
        r_prev_vld <= 1'b1;
      end
    end
  end

  // Stall timer: runs while driving hard in RUN, restarts on every legal hall step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall_arm && !w_legal) begin
      r_stall_cnt <= w_stall_nxt;
    end else begin
      r_stall_cnt <= '0;
    end
  end

  // Commutation period: saturating free-run counter captured on each legal hall step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_cnt <= '0;
      r_period  <= '1;
    end else if (w_legal) begin
      r_period  <= r_per_cnt;
      r_per_cnt <= 20'd1;
    end else if (r_per_cnt != '1) begin
      r_per_cnt <= r_per_cnt + 20'd1;
    end
  end

  mtr_seq_ctrl_mag_ramp #(
    .RampStep (RampStep)
  ) u_mag_ramp (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_run       (w_run_hold),
    .i_pwm_synch (i_pwm_synch),
    .i_mag_req   (i_drv_mag_req),
    .o_mag       (w_drv_mag)
  );

  assign o_drv_mag       = w_drv_mag;
  assign o_brake_n       = r_brake_n;
  assign o_fault         = r_fault;
  assign o_fault_code    = r_fault_code;
  assign o_commut_period = r_period;

endmodule
